crc16_tx_serializer: RTL and testbench
======================================

Name: crc16_tx_serializer

Overview:
Transmit-side counterpart of the USB CRC16 bit-serial generator. Accepts packet payload bytes over a valid/ready handshake and serializes each byte LSB-first on a bit strobe, updating a CRC16 register on every data bit. After the last byte it shifts out the 16-bit complemented remainder, MSB first. Sits between the TX packet buffer and the NRZI/bit-stuff encoder; bit timing comes from the external bit-rate timer.

Parameters:
CRC_POLY, 16'h8005, generator polynomial, x^16 implicit
CRC_INIT, 16'hFFFF, CRC register seed loaded on start

Ports:
clk  input  1  system clock
n_rst  input  1  reset
start  input  1  1-cycle pulse: begin packet; sampled only in IDLE
empty_pkt  input  1  qualifies start: zero-length payload, go straight to CRC phase
abort  input  1  synchronous return to IDLE from any state; no done pulse
data_byte  input  8  payload byte
byte_valid  input  1  data_byte/last_byte valid
last_byte  input  1  with byte_valid: final payload byte
byte_ready  output  1  block accepts byte this cycle (valid & ready = transfer)
bit_strobe  input  1  1-cycle pulse per bit period from bit timer
tx_bit  output  1  current serial bit to encoder
tx_active  output  1  high from start accept until done
done  output  1  1-cycle pulse after last CRC bit's strobe
crc_out  output  16  complemented CRC of last packet, held until next start
underrun  output  1  sticky: strobe arrived while waiting for byte; cleared on start

Behaviour:
- Reset n_rst, asynchronous, active-low; clock clk. Reset values: state IDLE, crc reg = CRC_INIT, crc_out 16'h0000, tx_bit 1, tx_active 0, byte_ready 0, done 0, underrun 0, counters 0.
- States: IDLE, LOAD, SHIFT_DATA, SHIFT_CRC, DONE.
- IDLE: tx_bit 1. start & !empty_pkt -> LOAD; start & empty_pkt -> SHIFT_CRC with crc_sr = ~CRC_INIT (16'h0000). Both: crc reg = CRC_INIT, underrun cleared, tx_active 1 from next cycle.
- LOAD: byte_ready = 1 (Moore, only in LOAD). On byte_valid: data_sr <= data_byte, last_q <= last_byte, bit_cnt <= 0 -> SHIFT_DATA. A bit_strobe seen in LOAD sets underrun; stay in LOAD, tx_bit holds previous value.
- SHIFT_DATA: tx_bit = data_sr[0]. On bit_strobe: fb = crc[15] ^ data_sr[0]; crc <= (crc<<1) ^ (fb ? CRC_POLY : 0); data_sr >>= 1; bit_cnt++. On the 8th strobe (bit_cnt==7): last_q -> SHIFT_CRC, loading crc_sr with ~(updated crc) that cycle; else -> LOAD.
- SHIFT_CRC: tx_bit = crc_sr[15]. On bit_strobe: crc_sr <<= 1, crc_cnt++. On 16th strobe -> DONE.
- DONE: done = 1 for exactly one cycle; crc_out <= ~crc; tx_active 0; -> IDLE.
- Latency: first data bit on tx_bit 2 clks after start (IDLE->LOAD->SHIFT_DATA, byte_valid already high). Upstream must hand each byte within 7 clks of leaving SHIFT_DATA at 8 clks/bit, else underrun.
- start outside IDLE ignored. abort wins over all events including the same-cycle strobe; crc_out unchanged, underrun retained. Async reset mid-packet: immediate reset values, no done.
- crc_out updates only in DONE.

Decomposition:
- Package crc16_pkg: CRC_POLY/CRC_INIT constants, USB residual 16'h800D, state enum type.
- Sub-module: crc16_bit_update (combinational next-CRC from crc, bit, enable, poly).

Test Plan:
- ASCII "123456789" (9 bytes, last on 0x39), strobe every 8 clks -> 72 data bits LSB-first, then CRC bits 0001_0011_0010_1101; crc_out 16'h132D; done once; underrun 0.
- start with empty_pkt=1 -> 16 zero bits, crc_out 16'h0000, done after 16th strobe, byte_ready never high.
- Loopback: feed tx_bit stream (data+CRC) of random 1–64 byte packets into a CRC16 checker with init 16'hFFFF -> final remainder 16'h800D every packet.
- byte_valid withheld 20 clks after first byte -> underrun=1 sticky, cleared by next start; byte_ready high throughout wait.
- abort mid-byte 3 of 5 -> IDLE next cycle, tx_active 0, no done, crc_out unchanged; new start runs a clean packet.
- Async n_rst during SHIFT_CRC -> all outputs at reset values immediately; start ignored while tx_active=1.

Source files
------------

// File: rtl/crc16_pkg.sv
// Shared constants and state encoding for the USB CRC16 transmit serializer.
package crc16_pkg;

  // Generator polynomial (x^16 implicit), register seed and the remainder a
  // receiver sees after clocking in payload plus transmitted CRC.
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_SHIFT_DATA = 3'd2,
    ST_SHIFT_CRC  = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

endpackage

// File: rtl/crc16_tx_serializer_if.sv
// Byte stream from the TX packet buffer into the serializer.
//
// Handshake: the source holds data_byte/last_byte stable while byte_valid is
// high; the sink raises byte_ready when it can take a byte. A byte moves on
// every rising clk edge where byte_valid && byte_ready are both high. The
// source may not make byte_valid depend on byte_ready.
interface crc16_tx_serializer_if;
  logic [7:0] data_byte;
  logic       byte_valid;
  logic       last_byte;
  logic       byte_ready;

  modport master (
    output data_byte,
    output byte_valid,
    output last_byte,
    input  byte_ready
  );

  modport slave (
    input  data_byte,
    input  byte_valid,
    input  last_byte,
    output byte_ready
  );
endinterface

// File: rtl/crc16_bit_update.sv
// One bit step of a left-shifting CRC16 register; passes crc_i through when
// en_i is low.
module crc16_bit_update
  import crc16_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic        bit_i,
  input  logic        en_i,
  input  logic [15:0] poly_i,
  output logic [15:0] crc_o
);

  logic fb;

  // Feedback is the outgoing MSB xored with the incoming data bit.
  always_comb begin
    fb    = crc_i[15] ^ bit_i;
    crc_o = crc_i;
    if (en_i) begin
      crc_o = {crc_i[14:0], 1'b0} ^ (fb ? poly_i : 16'h0000);
    end
  end

endmodule

// File: rtl/crc16_tx_serializer.sv
// Serializes payload bytes LSB-first on the bit strobe while accumulating a
// CRC16, then shifts out the complemented remainder MSB-first.
module crc16_tx_serializer
  import crc16_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = CRC16_POLY,
  parameter logic [15:0] CRC_INIT = CRC16_INIT
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic                        empty_pkt,
  input  logic                        abort,
  crc16_tx_serializer_if.slave        byte_if,
  input  logic                        bit_strobe,
  output logic                        tx_bit,
  output logic                        tx_active,
  output logic                        done,
  output logic [15:0]                 crc_out,
  output logic                        underrun,
  output state_t                      dbg_state
);

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_sr_q, crc_sr_d;
  logic [7:0]  data_sr_q, data_sr_d;
  logic        last_q, last_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  crc_cnt_q, crc_cnt_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic        underrun_q, underrun_d;
  logic        hold_bit_q, hold_bit_d;

  logic        crc_en;
  logic [15:0] crc_next;

  assign crc_en = (state_q == ST_SHIFT_DATA) && bit_strobe;

  crc16_bit_update u_crc_bit (
    .crc_i  (crc_q),
    .bit_i  (data_sr_q[0]),
    .en_i   (crc_en),
    .poly_i (CRC_POLY),
    .crc_o  (crc_next)
  );

  // Next-state, datapath updates and Moore outputs.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    crc_sr_d   = crc_sr_q;
    data_sr_d  = data_sr_q;
    last_d     = last_q;
    bit_cnt_d  = bit_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    crc_out_d  = crc_out_q;
    underrun_d = underrun_q;

    if (abort) begin
      // Abort beats every other event in the same cycle, strobe included.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            crc_d      = CRC_INIT;
            underrun_d = 1'b0;
            bit_cnt_d  = 3'd0;
            crc_cnt_d  = 4'd0;
            if (empty_pkt) begin
              crc_sr_d = ~CRC_INIT;
              state_d  = ST_SHIFT_CRC;
            end else begin
              state_d  = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (bit_strobe) begin
            underrun_d = 1'b1;
          end
          if (byte_if.byte_valid) begin
            data_sr_d = byte_if.data_byte;
            last_d    = byte_if.last_byte;
            bit_cnt_d = 3'd0;
            state_d   = ST_SHIFT_DATA;
          end
        end
        ST_SHIFT_DATA: begin
          if (bit_strobe) begin
            crc_d     = crc_next;
            data_sr_d = {1'b0, data_sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (last_q) begin
                crc_sr_d  = ~crc_next;
                crc_cnt_d = 4'd0;
                state_d   = ST_SHIFT_CRC;
              end else begin
                state_d   = ST_LOAD;
              end
            end
          end
        end
        ST_SHIFT_CRC: begin
          if (bit_strobe) begin
            crc_sr_d  = {crc_sr_q[14:0], 1'b0};
            crc_cnt_d = crc_cnt_q + 4'd1;
            if (crc_cnt_q == 4'd15) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          crc_out_d = ~crc_q;
          state_d   = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Line idles high; LOAD and DONE keep whatever bit was last driven.
    case (state_q)
      ST_IDLE:       tx_bit = 1'b1;
      ST_SHIFT_DATA: tx_bit = data_sr_q[0];
      ST_SHIFT_CRC:  tx_bit = crc_sr_q[15];
      default:       tx_bit = hold_bit_q;
    endcase
    hold_bit_d = tx_bit;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      crc_q      <= CRC_INIT;
      crc_sr_q   <= 16'h0000;
      data_sr_q  <= 8'h00;
      last_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      crc_cnt_q  <= 4'd0;
      crc_out_q  <= 16'h0000;
      underrun_q <= 1'b0;
      hold_bit_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      crc_sr_q   <= crc_sr_d;
      data_sr_q  <= data_sr_d;
      last_q     <= last_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      crc_out_q  <= crc_out_d;
      underrun_q <= underrun_d;
      hold_bit_q <= hold_bit_d;
    end
  end

  assign byte_if.byte_ready = (state_q == ST_LOAD);
  assign tx_active = (state_q == ST_LOAD) || (state_q == ST_SHIFT_DATA) ||
                     (state_q == ST_SHIFT_CRC);
  assign done      = (state_q == ST_DONE);
  assign crc_out   = crc_out_q;
  assign underrun  = underrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_crc16_tx_serializer.sv
// Directed bench for crc16_tx_serializer: table of packets with known CRCs,
// random loopback packets checked against the USB residual, and hand-written
// underrun / abort / restart / async-reset sequences.
module tb_crc16_tx_serializer;
  import crc16_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start = 1'b0;
  logic        empty_pkt = 1'b0;
  logic        abort = 1'b0;
  logic        bit_strobe = 1'b0;
  logic        tx_bit;
  logic        tx_active;
  logic        done;
  logic [15:0] crc_out;
  logic        underrun;
  state_t      dbg_state;

  crc16_tx_serializer_if byte_if ();

  // Clock and reset
  always #5 clk = ~clk;

  crc16_tx_serializer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .empty_pkt  (empty_pkt),
    .abort      (abort),
    .byte_if    (byte_if.slave),
    .bit_strobe (bit_strobe),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .done       (done),
    .crc_out    (crc_out),
    .underrun   (underrun),
    .dbg_state  (dbg_state)
  );

  typedef struct packed {
    logic [6:0]  len;
    logic [71:0] bytes;
    logic        empty;
    logic        use_const;
    logic [15:0] exp_crc;
  } vec_t;

  vec_t        vecs [5];
  logic [7:0]  pkt [64];
  int          pkt_len;
  logic [0:0]  exp_q [$];
  logic [0:0]  cap_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          r_done, r_ready, r_wait_ready;
  bit          r_finished;
  logic [15:0] prev_crc;

  // Scoreboard helpers
  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < pkt_len; i++)
      for (int b = 0; b < 8; b++)
        c = crc_step(c, pkt[i][b]);
    return ~c;
  endfunction

  task automatic chk_stream(input string name);
    logic [15:0] cc;
    logic [15:0] rc;
    int          n;
    exp_q.delete();
    for (int i = 0; i < pkt_len; i++)
      for (int b = 0; b < 8; b++)
        exp_q.push_back(pkt[i][b]);
    cc = model_crc();
    for (int b = 15; b >= 0; b--)
      exp_q.push_back(cc[b]);
    chki({name, " nbits"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk1($sformatf("%s bit%0d", name, i), cap_q[i], exp_q[i]);
    rc = 16'hFFFF;
    for (int i = 0; i < cap_q.size(); i++)
      rc = crc_step(rc, cap_q[i]);
    chk16({name, " residual"}, rc, 16'h800D);
  endtask

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (done) r_done++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_random(input int n);
    pkt_len = n;
    for (int j = 0; j < n; j++) pkt[j] = 8'($urandom_range(0, 255));
  endtask

  // Runs one packet: start in cycle 0, strobe every 8th cycle, bytes offered
  // whenever pending. Optional withhold of byte 1, abort, second start, and
  // async reset at given cycles.
  task automatic run_packet(input bit empty, input int withhold, input int abort_cyc,
                            input int restart_cyc, input int rst_cyc);
    int idx, cyc, wait_cnt, budget;
    bit withholding, xfer;
    idx = 0; cyc = 0; wait_cnt = 0;
    r_done = 0; r_ready = 0; r_wait_ready = 0; r_finished = 0;
    cap_q.delete();
    budget = pkt_len * 64 + withhold + 400;
    while (!r_finished && cyc < budget) begin
      start      = (cyc == 0) || (restart_cyc != 0 && cyc == restart_cyc);
      empty_pkt  = empty;
      abort      = (abort_cyc != 0 && cyc == abort_cyc);
      bit_strobe = (cyc > 0) && (cyc % 8 == 0);
      withholding = (withhold > 0) && (idx == 1) && (wait_cnt < withhold);
      byte_if.byte_valid = !empty && (idx < pkt_len) && !withholding;
      byte_if.data_byte  = (idx < pkt_len) ? pkt[idx] : 8'h00;
      byte_if.last_byte  = (idx == pkt_len - 1);
      @(negedge clk);
      if (cyc == 1) begin
        chk1("lat tx_active", tx_active, 1'b1);
        chk1("lat byte_ready", byte_if.byte_ready, !empty);
      end
      if (cyc == 2 && !empty) chk1("lat shift", byte_if.byte_ready, 1'b0);
      if (bit_strobe && tx_active) cap_q.push_back(tx_bit);
      if (byte_if.byte_ready) r_ready++;
      if (withholding && (wait_cnt > 0 || byte_if.byte_ready)) begin
        wait_cnt++;
        if (byte_if.byte_ready) r_wait_ready++;
      end
      if (done) begin
        r_done++;
        r_finished = 1;
      end
      xfer = byte_if.byte_valid && byte_if.byte_ready;
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        n_rst = 1'b0;
        #1;
        r_finished = 1;
      end else begin
        @(posedge clk);
        #1;
        if (xfer) idx++;
        if (abort) r_finished = 1;
      end
      cyc++;
    end
    start = 0; abort = 0; bit_strobe = 0; empty_pkt = 0;
    byte_if.byte_valid = 0; byte_if.last_byte = 0;
    if (!r_finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: packet did not end within %0d cycles", cyc);
    end
  endtask

  task automatic check_clean(input string name);
    idle(4);
    chki({name, " done count"}, r_done, 1);
    chk16({name, " crc_out"}, crc_out, model_crc());
    chk1({name, " underrun"}, underrun, 1'b0);
    chk1({name, " tx_active"}, tx_active, 1'b0);
    chk_stream(name);
  endtask

  task automatic chk_reset_vals(input string name);
    chk1({name, " tx_bit"}, tx_bit, 1'b1);
    chk1({name, " tx_active"}, tx_active, 1'b0);
    chk1({name, " byte_ready"}, byte_if.byte_ready, 1'b0);
    chk1({name, " done"}, done, 1'b0);
    chk1({name, " underrun"}, underrun, 1'b0);
    chk16({name, " crc_out"}, crc_out, 16'h0000);
    chki({name, " state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{len: 7'd9, bytes: 72'h393837363534333231, empty: 1'b0,
                use_const: 1'b1, exp_crc: 16'h132D};
    vecs[1] = '{len: 7'd0, bytes: 72'h0, empty: 1'b1, use_const: 1'b1, exp_crc: 16'h0000};
    vecs[2] = '{len: 7'd1, bytes: 72'h00, empty: 1'b0, use_const: 1'b0, exp_crc: 16'h0000};
    vecs[3] = '{len: 7'd4, bytes: 72'hFFFFFFFF, empty: 1'b0, use_const: 1'b0, exp_crc: 16'h0000};
    vecs[4] = '{len: 7'd2, bytes: 72'hA55A, empty: 1'b0, use_const: 1'b0, exp_crc: 16'h0000};

    byte_if.data_byte = 8'h00; byte_if.byte_valid = 1'b0; byte_if.last_byte = 1'b0;
    #2 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;
    idle(2);
    chk_reset_vals("post reset");

    // Table of packets
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      pkt_len = int'(v.len);
      for (int j = 0; j < pkt_len; j++) pkt[j] = v.bytes[8*j +: 8];
      run_packet(v.empty, 0, 0, 0, 0);
      idle(4);
      chki($sformatf("vec%0d done count", i), r_done, 1);
      chk16($sformatf("vec%0d crc_out", i), crc_out, v.use_const ? v.exp_crc : model_crc());
      chk1($sformatf("vec%0d underrun", i), underrun, 1'b0);
      chk1($sformatf("vec%0d tx_active", i), tx_active, 1'b0);
      chk_stream($sformatf("vec%0d", i));
      if (v.empty) chki($sformatf("vec%0d ready cycles", i), r_ready, 0);
    end

    // Random loopback packets
    for (int p = 0; p < 5; p++) begin
      fill_random($urandom_range(1, 64));
      run_packet(1'b0, 0, 0, 0, 0);
      check_clean($sformatf("rand%0d", p));
    end

    // Byte withheld 20 cycles while waiting in LOAD
    fill_random(3);
    run_packet(1'b0, 20, 0, 0, 0);
    idle(4);
    chki("withhold ready cycles", r_wait_ready, 20);
    chki("withhold done count", r_done, 1);
    chk1("withhold underrun", underrun, 1'b1);
    chk16("withhold crc_out", crc_out, model_crc());
    idle(10);
    chk1("underrun sticky", underrun, 1'b1);
    fill_random(2);
    run_packet(1'b0, 0, 0, 0, 0);
    check_clean("after underrun");
    prev_crc = model_crc();

    // Abort in the middle of byte 3 of 5
    fill_random(5);
    run_packet(1'b0, 0, 160, 0, 0);
    chk1("abort tx_active", tx_active, 1'b0);
    chk1("abort tx_bit", tx_bit, 1'b1);
    chk1("abort byte_ready", byte_if.byte_ready, 1'b0);
    chki("abort state", int'(dbg_state), int'(ST_IDLE));
    r_done = 0;
    idle(20);
    chki("abort no done", r_done, 0);
    chk16("abort crc_out kept", crc_out, prev_crc);
    fill_random(3);
    run_packet(1'b0, 0, 0, 0, 0);
    check_clean("after abort");

    // Second start while the packet is running
    fill_random(2);
    run_packet(1'b0, 0, 0, 40, 0);
    check_clean("restart ignored");

    // Async reset in the CRC phase
    fill_random(1);
    run_packet(1'b0, 0, 0, 0, 90);
    chk_reset_vals("async reset");
    @(negedge clk);
    n_rst = 1'b1;
    r_done = 0;
    idle(3);
    chki("async reset no done", r_done, 0);
    fill_random(1);
    run_packet(1'b0, 0, 0, 0, 0);
    check_clean("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
